// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: states, opcodes, ALU codes, select encodings.
// Build option: define ILLEGAL_OP_TRAP_EN to add the TRAP state for illegal opcodes.
package mc_ctrl_pkg;

   localparam int ST_BITS = 4;
   localparam int OP_BITS = 6;

   typedef enum logic [ST_BITS-1:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_R_EX     = 4'd6,
      S_R_WB     = 4'd7,
      S_ADDI_EX  = 4'd8,
      S_ADDI_WB  = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11
`ifdef ILLEGAL_OP_TRAP_EN
      ,
      S_TRAP     = 4'd12
`endif
   } state_t;

   localparam logic [OP_BITS-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_BITS-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_BITS-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_BITS-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_BITS-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_BITS-1:0] OP_BNE   = 6'b000101;
   localparam logic [OP_BITS-1:0] OP_BGT   = 6'b000111;
   localparam logic [OP_BITS-1:0] OP_BLE   = 6'b000110;
   localparam logic [OP_BITS-1:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_BEQ   = 3'b001;
   localparam logic [2:0] ALU_RTYPE = 3'b010;
   localparam logic [2:0] ALU_BNE   = 3'b011;
   localparam logic [2:0] ALU_BLE   = 3'b101;
   localparam logic [2:0] ALU_BGT   = 3'b111;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Field order matches the top-level port list so the bundle is easy to probe.
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic [1:0] pc_source;
      logic       trap;
   } ctrl_t;

   function automatic logic is_branch(input logic [OP_BITS-1:0] op);
      return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BGT) || (op == OP_BLE);
   endfunction

   function automatic logic is_mem(input logic [OP_BITS-1:0] op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

   // Compare flavour handed to ALU control while the branch resolves.
   function automatic logic [2:0] branch_alu_op(input logic [OP_BITS-1:0] op);
      logic [2:0] code;
      code = ALU_ADD;
      case (op)
         OP_BEQ:  code = ALU_BEQ;
         OP_BNE:  code = ALU_BNE;
         OP_BGT:  code = ALU_BGT;
         OP_BLE:  code = ALU_BLE;
         default: code = ALU_ADD;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational map from FSM state (plus opcode and mem_ready) to datapath strobes.
// Build option: ILLEGAL_OP_TRAP_EN adds the TRAP output pattern.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
#(
   parameter int OPW = 6
) (
   input  state_t         state,
   input  logic [OPW-1:0] opcode,
   input  logic           mem_ready,
   output ctrl_t          ctrl
);

   always_comb begin
      // NOTE: every field gets a default before the case so no path can infer a latch.
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.i_or_d    = 1'b0;
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_a = 1'b0;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALU_ADD;
            ctrl.pc_source = PCSRC_ALU;
            // PC and IR load only on the cycle memory actually returns the word.
            ctrl.pc_write  = mem_ready;
            ctrl.ir_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_a = 1'b0;
            ctrl.alu_src_b = SRCB_IMM_SH;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEM_ADDR, S_ADDI_EX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEM_RD: begin
            ctrl.i_or_d   = 1'b1;
            ctrl.mem_read = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_dst    = 1'b0;
         end
         S_MEM_WR: begin
            ctrl.i_or_d    = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         S_R_EX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_B;
            ctrl.alu_op    = ALU_RTYPE;
         end
         S_R_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b1;
            ctrl.mem_to_reg = 1'b0;
         end
         S_ADDI_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b0;
            ctrl.mem_to_reg = 1'b0;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_B;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
            ctrl.alu_op        = branch_alu_op(opcode);
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
         end
`ifdef ILLEGAL_OP_TRAP_EN
         S_TRAP: begin
            ctrl.trap = 1'b1;
         end
`endif
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: state register, next-state logic, output gating.
// Build option: define ILLEGAL_OP_TRAP_EN to trap on illegal opcodes instead of treating them as NOPs.
module multicycle_control
   import mc_ctrl_pkg::*;
#(
   parameter int OPW = 6,
   parameter int STW = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [OPW-1:0] opcode,
   input  logic           mem_ready,
   output logic           pc_write,
   output logic           pc_write_cond,
   output logic           i_or_d,
   output logic           mem_read,
   output logic           mem_write,
   output logic           ir_write,
   output logic           mem_to_reg,
   output logic           reg_dst,
   output logic           reg_write,
   output logic           alu_src_a,
   output logic [1:0]     alu_src_b,
   output logic [2:0]     alu_op,
   output logic [1:0]     pc_source,
   output logic           trap,
   output logic [STW-1:0] state
);

   state_t state_q;
   ctrl_t  ctrl_raw;
   ctrl_t  ctrl;

   // NOTE: sequential state uses non-blocking assignments only, so every reader sees the pre-edge value.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (mem_ready) state_q <= S_DECODE;
            end
            S_DECODE: begin
               if (is_mem(opcode))          state_q <= S_MEM_ADDR;
               else if (opcode == OP_ADDI)  state_q <= S_ADDI_EX;
               else if (opcode == OP_RTYPE) state_q <= S_R_EX;
               else if (is_branch(opcode))  state_q <= S_BRANCH;
               else if (opcode == OP_J)     state_q <= S_JUMP;
               else begin
`ifdef ILLEGAL_OP_TRAP_EN
                  state_q <= S_TRAP;
`else
                  // Illegal opcode retires as a NOP; PC was already advanced in FETCH.
                  state_q <= S_FETCH;
`endif
               end
            end
            S_MEM_ADDR: begin
               if (opcode == OP_LW)      state_q <= S_MEM_RD;
               else if (opcode == OP_SW) state_q <= S_MEM_WR;
               else                      state_q <= S_FETCH;
            end
            S_MEM_RD: begin
               if (mem_ready) state_q <= S_MEM_WB;
            end
            S_MEM_WR: begin
               if (mem_ready) state_q <= S_FETCH;
            end
            S_R_EX:    state_q <= S_R_WB;
            S_ADDI_EX: state_q <= S_ADDI_WB;
            S_MEM_WB,
            S_R_WB,
            S_ADDI_WB,
            S_BRANCH,
            S_JUMP:    state_q <= S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP:    state_q <= S_TRAP;
`endif
            default:   state_q <= S_FETCH;
         endcase
      end
   end

   mc_ctrl_decode #(
      .OPW (OPW)
   ) u_decode (
      .state     (state_q),
      .opcode    (opcode),
      .mem_ready (mem_ready),
      .ctrl      (ctrl_raw)
   );

   // Reset is synchronous, so the register may still hold a live state; mask outputs while it is high.
   assign ctrl  = reset ? '0 : ctrl_raw;
   assign state = reset ? STW'(S_FETCH) : STW'(state_q);

   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign i_or_d        = ctrl.i_or_d;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign ir_write      = ctrl.ir_write;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign reg_dst       = ctrl.reg_dst;
   assign reg_write     = ctrl.reg_write;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign alu_op        = ctrl.alu_op;
   assign pc_source     = ctrl.pc_source;
   assign trap          = ctrl.trap;

endmodule
